// File: rtl/pll_reconfig_sequencer.sv
// rtl/pll_reconfig_sequencer.sv - NTSC/PAL PLL reprogramming sequencer with core reset hold-off
module pll_reconfig_sequencer #(
  parameter logic [31:0] NTSC_K      = 32'd425907062,
  parameter logic [31:0] PAL_K       = 32'd1009730048,
  parameter int          LOCK_STABLE = 1024,
  parameter int          TIMEOUT     = 1 << 20
) (
  input  logic        clk_74a,
  input  logic        reset_n,
  input  logic        req,
  input  logic        profile,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic        core_reset_n,
  output logic [5:0]  mgmt_address,
  output logic        mgmt_write,
  output logic        mgmt_read,
  output logic [31:0] mgmt_writedata,
  input  logic [31:0] mgmt_readdata,
  input  logic        mgmt_waitrequest,
  input  logic        pll_locked
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int SW = $clog2(LOCK_STABLE + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_HOLD, S_WRITE, S_POLL, S_WAIT, S_RELEASE
  } state_t;

  state_t      r_state;
  logic [1:0]  r_sync;
  logic [3:0]  r_idx;
  logic [TW-1:0] r_timer;
  logic [SW-1:0] r_stable;
  logic        r_profile, r_pend, r_pend_prof, r_boot;
  logic        r_busy, r_done, r_error, r_core, r_write, r_read;
  logic [5:0]  r_addr;
  logic [31:0] r_wdata;

  // {address, data} of each word in the reprogramming sequence
  function automatic logic [37:0] word_of(input logic [3:0] idx, input logic prof);
    case (idx)
      4'd0:    word_of = {6'h00, 32'd1};
      4'd1:    word_of = {6'h04, prof ? 32'h0000_0505 : 32'h0000_0404};
      4'd2:    word_of = {6'h03, 32'h0001_0000};
      4'd3:    word_of = {6'h05, 32'h0002_0403};
      4'd4:    word_of = {6'h05, 32'h0004_0E0E};
      4'd5:    word_of = {6'h05, 32'h0008_3838};
      4'd6:    word_of = {6'h05, 32'h000C_3838};
      4'd7:    word_of = {6'h07, prof ? PAL_K : NTSC_K};
      default: word_of = {6'h02, 32'd0};
    endcase
  endfunction

  logic [37:0] w_word_first, w_word_next;
  logic        w_pend, w_pend_prof, w_status, w_unused;

  assign w_word_first = word_of(4'd0, r_profile);
  assign w_word_next  = word_of(r_idx + 4'd1, r_profile);
  // a request landing in the very cycle the sequence ends still counts as pending
  assign w_pend       = r_pend | req;
  assign w_pend_prof  = req ? profile : r_pend_prof;
  assign w_status     = mgmt_readdata[0];
  assign w_unused     = ^mgmt_readdata[31:1];

  always_ff @(posedge clk_74a or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_sync      <= 2'b00;
      r_idx       <= 4'd0;
      r_timer     <= '0;
      r_stable    <= '0;
      r_profile   <= 1'b0;
      r_pend      <= 1'b0;
      r_pend_prof <= 1'b0;
      r_boot      <= 1'b1;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_error     <= 1'b0;
      r_core      <= 1'b0;
      r_write     <= 1'b0;
      r_read      <= 1'b0;
      r_addr      <= 6'd0;
      r_wdata     <= 32'd0;
    end else begin
      r_sync <= {r_sync[0], pll_locked};
      r_done <= 1'b0;
      if (req && !(r_state == S_IDLE && !r_boot)) begin
        r_pend      <= 1'b1;
        r_pend_prof <= profile;
      end
      case (r_state)
        S_IDLE: begin
          if (r_boot) begin
            r_timer  <= '0;
            r_stable <= '0;
            r_state  <= S_WAIT;
          end else if (req) begin
            r_profile <= profile;
            r_error   <= 1'b0;
            r_busy    <= 1'b1;
            r_core    <= 1'b0;
            r_state   <= S_HOLD;
          end
        end
        S_HOLD: begin
          r_core             <= 1'b0;
          r_idx              <= 4'd0;
          r_write            <= 1'b1;
          {r_addr, r_wdata}  <= w_word_first;
          r_state            <= S_WRITE;
        end
        S_WRITE: begin
          if (!mgmt_waitrequest) begin
            if (r_idx == 4'd8) begin
              r_write <= 1'b0;
              r_read  <= 1'b1;
              r_addr  <= 6'h01;
              r_wdata <= 32'd0;
              r_timer <= '0;
              r_state <= S_POLL;
            end else begin
              r_idx             <= r_idx + 4'd1;
              {r_addr, r_wdata} <= w_word_next;
            end
          end
        end
        S_POLL: begin
          if (!mgmt_waitrequest && w_status) begin
            r_read   <= 1'b0;
            r_addr   <= 6'd0;
            r_timer  <= '0;
            r_stable <= '0;
            r_state  <= S_WAIT;
          end else if (r_timer == TW'(TIMEOUT - 1)) begin
            r_read  <= 1'b0;
            r_addr  <= 6'd0;
            r_error <= 1'b1;
            r_core  <= 1'b0;
            r_boot  <= 1'b0;
            if (w_pend) begin
              r_profile <= w_pend_prof;
              r_pend    <= 1'b0;
              r_state   <= S_HOLD;
            end else begin
              r_busy  <= 1'b0;
              r_state <= S_IDLE;
            end
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end
        S_WAIT: begin
          if (r_sync[1] && r_stable == SW'(LOCK_STABLE - 1)) begin
            r_state <= S_RELEASE;
          end else if (r_timer == TW'(TIMEOUT - 1)) begin
            r_error <= 1'b1;
            r_core  <= 1'b0;
            r_boot  <= 1'b0;
            if (w_pend) begin
              r_profile <= w_pend_prof;
              r_pend    <= 1'b0;
              r_busy    <= 1'b1;
              r_state   <= S_HOLD;
            end else begin
              r_busy  <= 1'b0;
              r_state <= S_IDLE;
            end
          end else begin
            r_timer  <= r_timer + 1'b1;
            r_stable <= r_sync[1] ? r_stable + 1'b1 : '0;
          end
        end
        S_RELEASE: begin
          // the power-on release is not a requested sequence, so it raises no done
          r_core <= 1'b1;
          r_done <= !r_boot;
          r_boot <= 1'b0;
          if (w_pend) begin
            r_profile <= w_pend_prof;
            r_pend    <= 1'b0;
            r_busy    <= 1'b1;
            r_state   <= S_HOLD;
          end else begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy           = r_busy;
  assign done           = r_done;
  assign error          = r_error;
  assign core_reset_n   = r_core;
  assign mgmt_address   = r_addr;
  assign mgmt_write     = r_write;
  assign mgmt_read      = r_read;
  assign mgmt_writedata = r_wdata;

endmodule

// File: tb/tb_pll_reconfig_sequencer.sv
// tb/tb_pll_reconfig_sequencer.sv - directed/randomized bench for pll_reconfig_sequencer
module tb_pll_reconfig_sequencer;
  localparam int LS = 1024;
  localparam int TO = 4096;
  localparam logic [31:0] NK = 32'd425907062;
  localparam logic [31:0] PK = 32'd1009730048;

  logic        clk_74a = 1'b0;
  logic        reset_n = 1'b0;
  logic        req = 1'b0;
  logic        profile = 1'b0;
  logic        pll_locked = 1'b0;
  logic        mgmt_waitrequest = 1'b0;
  logic [31:0] mgmt_readdata = 32'd0;
  logic        busy, done, error, core_reset_n, mgmt_write, mgmt_read;
  logic [5:0]  mgmt_address;
  logic [31:0] mgmt_writedata;

  pll_reconfig_sequencer #(
    .NTSC_K(NK), .PAL_K(PK), .LOCK_STABLE(LS), .TIMEOUT(TO)
  ) dut (
    .clk_74a(clk_74a), .reset_n(reset_n), .req(req), .profile(profile),
    .busy(busy), .done(done), .error(error), .core_reset_n(core_reset_n),
    .mgmt_address(mgmt_address), .mgmt_write(mgmt_write), .mgmt_read(mgmt_read),
    .mgmt_writedata(mgmt_writedata), .mgmt_readdata(mgmt_readdata),
    .mgmt_waitrequest(mgmt_waitrequest), .pll_locked(pll_locked)
  );

  always #5 clk_74a = ~clk_74a;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  bit stall_en = 0;
  bit status_never = 0;
  int status_after = 0;
  int reads_acc, done_cnt, rise_step, done_step, first_read_step, status_step;
  logic [5:0]  wq_a[$];
  logic [31:0] wq_d[$];
  int          wq_s[$];
  bit          p_stall = 0;
  logic [5:0]  p_addr;
  logic [31:0] p_wdata;
  logic        p_wr, p_rd;
  logic        p_core = 1'b0;

  logic [5:0]  EXP_A [9] = '{6'h00, 6'h04, 6'h03, 6'h05, 6'h05, 6'h05, 6'h05, 6'h07, 6'h02};
  logic [31:0] EXP_D [9] = '{32'd1, 32'd0, 32'h10000, 32'h020403, 32'h040E0E,
                             32'h083838, 32'h0C3838, 32'd0, 32'd0};

  function automatic logic [37:0] exp_word(int i, bit p);
    logic [31:0] d;
    d = EXP_D[i];
    if (i == 1) d = p ? 32'h505 : 32'h404;
    if (i == 7) d = p ? PK : NK;
    return {EXP_A[i], d};
  endfunction

  task automatic chk(string tag, longint obs, longint expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic clear_vars();
    wq_a.delete(); wq_d.delete(); wq_s.delete();
    reads_acc = 0; done_cnt = 0; rise_step = -1; done_step = -1;
    first_read_step = -1; status_step = -1;
  endtask

  // one clock: sample DUT, check Avalon protocol, act as the reconfig controller
  task automatic step();
    logic wr;
    logic b0;
    @(posedge clk_74a);
    #1;
    cyc++;
    if (p_stall) begin
      chk("hold_addr", longint'(mgmt_address), longint'(p_addr));
      chk("hold_wdata", longint'(mgmt_writedata), longint'(p_wdata));
      chk("hold_strobe", longint'({mgmt_write, mgmt_read}), longint'({p_wr, p_rd}));
    end
    if (mgmt_write || mgmt_read) chk("strobe_overlap", longint'(mgmt_write & mgmt_read), 0);
    if (done) begin done_cnt++; done_step = cyc; end
    if (core_reset_n && !p_core) rise_step = cyc;
    p_core = core_reset_n;
    if (mgmt_read && first_read_step < 0) first_read_step = cyc;
    wr = stall_en ? ($urandom_range(0, 99) < 40) : 1'b0;
    b0 = 1'b0;
    if (mgmt_read && !wr) begin
      reads_acc++;
      b0 = !status_never && (reads_acc > status_after);
      if (b0) status_step = cyc;
    end
    if (mgmt_write && !wr) begin
      wq_a.push_back(mgmt_address); wq_d.push_back(mgmt_writedata); wq_s.push_back(cyc);
    end
    mgmt_waitrequest = wr;
    mgmt_readdata = {$urandom_range(0, 32'h7FFF_FFFF), b0};
    p_stall = (mgmt_write || mgmt_read) && wr;
    p_addr = mgmt_address; p_wdata = mgmt_writedata; p_wr = mgmt_write; p_rd = mgmt_read;
  endtask

  task automatic check_words(int base, bit p, string tag);
    logic [37:0] got;
    for (int i = 0; i < 9; i++) begin
      got = (base + i < wq_a.size()) ? {wq_a[base+i], wq_d[base+i]} : '1;
      chk($sformatf("%s_word%0d", tag, i), longint'(got), longint'(exp_word(i, p)));
    end
  endtask

  task automatic issue(bit p, output int k);
    k = cyc;
    req = 1'b1; profile = p;
    step();
    req = 1'b0;
  endtask

  task automatic wait_done(int n, int bound, string tag);
    for (int i = 0; i < bound && done_cnt < n; i++) step();
    chk(tag, longint'(done_cnt >= n), 1);
  endtask

  initial begin
    int k, r;
    bit busy_drop;
    clear_vars();
    repeat (3) step();
    chk("rst_busy", longint'(busy), 0);
    chk("rst_done", longint'(done), 0);
    chk("rst_error", longint'(error), 0);
    chk("rst_core", longint'(core_reset_n), 0);
    chk("rst_bus", longint'({mgmt_write, mgmt_read, mgmt_address, mgmt_writedata}), 0);

    reset_n = 1'b1;
    repeat (500) step();
    chk("boot_core_low", longint'(core_reset_n), 0);
    pll_locked = 1'b1;
    r = cyc;
    for (int i = 0; i < 3000 && rise_step < 0; i++) step();
    chk("boot_release_lat", longint'(rise_step - r), LS + 3);
    chk("boot_no_writes", longint'(wq_a.size()), 0);
    chk("boot_no_reads", longint'(first_read_step), -1);
    chk("boot_no_done", longint'(done_cnt), 0);

    clear_vars();
    stall_en = 0; status_after = $urandom_range(0, 3);
    issue(1'b0, k);
    wait_done(1, 3000, "ntsc_done_seen");
    chk("ntsc_nwrites", longint'(wq_a.size()), 9);
    check_words(0, 1'b0, "ntsc");
    chk("ntsc_first_write", longint'(wq_s[0] - k), 2);
    chk("ntsc_last_write", longint'(wq_s[8] - k), 10);
    chk("ntsc_first_read", longint'(first_read_step - k), 11);
    chk("ntsc_reads", longint'(reads_acc), longint'(status_after + 1));
    chk("ntsc_lock_lat", longint'(rise_step - status_step), LS + 2);
    chk("ntsc_done_with_rise", longint'(done_step), longint'(rise_step));
    step();
    chk("ntsc_idle", longint'({busy, done, core_reset_n}), 1);

    clear_vars();
    stall_en = 1; status_after = $urandom_range(0, 4);
    issue(1'b1, k);
    wait_done(1, 4000, "pal_done_seen");
    chk("pal_nwrites", longint'(wq_a.size()), 9);
    check_words(0, 1'b1, "pal");
    chk("pal_reads", longint'(reads_acc), longint'(status_after + 1));
    chk("pal_lock_lat", longint'(rise_step - status_step), LS + 2);
    chk("pal_done_with_rise", longint'(done_step), longint'(rise_step));
    stall_en = 0;

    clear_vars();
    status_after = 0; busy_drop = 0;
    issue(1'b1, k);
    repeat (3) step();
    issue(1'b0, r);
    for (int i = 0; i < 6000 && done_cnt < 2; i++) begin
      step();
      if (done_cnt < 2 && !busy) busy_drop = 1;
    end
    chk("pend_two_done", longint'(done_cnt), 2);
    chk("pend_busy_held", longint'(busy_drop), 0);
    chk("pend_nwrites", longint'(wq_a.size()), 18);
    check_words(0, 1'b1, "pend_pal");
    check_words(9, 1'b0, "pend_ntsc");
    repeat (5) step();
    chk("pend_no_extra", longint'({done_cnt, busy}), longint'({32'd2, 1'b0}));

    clear_vars();
    pll_locked = 1'b0;
    issue(1'b0, k);
    for (int i = 0; i < 200 && status_step < 0; i++) step();
    repeat (2) step();
    pll_locked = 1'b1;
    repeat (602) step();
    pll_locked = 1'b0;
    repeat (3) step();
    pll_locked = 1'b1;
    r = cyc;
    for (int i = 0; i < 3000 && rise_step < 0; i++) step();
    chk("drop_release_lat", longint'(rise_step - r), LS + 3);
    chk("drop_done", longint'(done_cnt), 1);

    clear_vars();
    status_never = 1;
    issue(1'b1, k);
    for (int i = 0; i < TO + 500 && busy; i++) step();
    chk("to_latency", longint'(cyc - k), TO + 11);
    chk("to_error", longint'(error), 1);
    chk("to_core_low", longint'(core_reset_n), 0);
    chk("to_no_done", longint'(done_cnt), 0);
    chk("to_read_off", longint'(mgmt_read), 0);
    status_never = 0;
    clear_vars();
    status_after = 1;
    issue(1'b0, k);
    chk("err_cleared", longint'({error, busy}), 1);
    wait_done(1, 3000, "retry_done_seen");
    check_words(0, 1'b0, "retry");
    chk("retry_end", longint'({error, core_reset_n}), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
